// File: rtl/register_reader.sv
// register_reader: scans a register-file read port and shows the selected word on a 4-digit 7-segment display.
// Optional REGISTER_READER_AUTO_STEP_EN adds a free-running auto-step every 2^27 cycles.
module register_reader #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              next,
  input  logic              half_sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              dp
);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t r_state;
  logic r_next_d, r_pend;
  logic [WIDTH-1:0] r_shadow;
  logic [DIV_W-1:0] r_div;
  logic [1:0] r_idx;
  logic w_edge, w_step, w_tc, w_wrap;
  logic [4:0] w_bit;
  logic [3:0] w_nib;
  logic [6:0] w_seg;
  assign w_edge = next & ~r_next_d;
  assign w_tc = r_div == DIV_W'(REFRESH_DIV - 1);
  assign w_wrap = w_tc && r_idx == 2'd3;
  assign w_bit = {half_sel, r_idx, 2'b00};
  assign w_nib = r_shadow[w_bit +: 4];
`ifdef REGISTER_READER_AUTO_STEP_EN
  logic [26:0] r_auto;
  always_ff @(posedge clk)
    r_auto <= (reset || w_edge) ? '0 : r_auto + 27'd1;
  assign w_step = w_edge | (&r_auto);
`else
  assign w_step = w_edge;
`endif
  always_comb begin
    w_seg = 7'b1000000;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      default: w_seg = 7'b0001110;
    endcase
  end
  // Steps seen while a read is in flight collapse into one pending increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_next_d <= 1'b0;
      r_pend <= 1'b0;
      r_shadow <= '0;
      rd_en <= 1'b0;
      rd_addr <= '0;
    end else begin
      r_next_d <= next;
      case (r_state)
        IDLE: begin
          if (w_step || r_pend) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            r_pend <= 1'b0;
            rd_en <= 1'b1;
            r_state <= ISSUE;
          end else if (w_wrap) begin
            rd_en <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          rd_en <= 1'b0;
          r_state <= CAPTURE;
          if (w_step) r_pend <= 1'b1;
        end
        CAPTURE: begin
          r_shadow <= rd_data;
          r_state <= IDLE;
          if (w_step) r_pend <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= 2'd0;
      an <= 4'b1110;
      seg <= 7'b1000000;
      dp <= 1'b1;
    end else begin
      r_div <= w_tc ? '0 : r_div + DIV_W'(1);
      if (w_tc) r_idx <= r_idx + 2'd1;
      an <= ~(4'b0001 << r_idx);
      seg <= w_seg;
      dp <= ~(half_sel & (r_idx == 2'd3));
    end
  end
endmodule

// File: tb/tb_register_reader.sv
// tb_register_reader: directed checks of read FSM, pending collapse, address wrap, display mux and reset abort.
module tb_register_reader;
  logic clk = 1'b0, reset = 1'b1, next = 1'b0, half_sel = 1'b0;
  logic rd_en;
  logic [4:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp;
  logic ff_mode = 1'b0;
  int checks = 0, failures = 0, cyc = 0;
  logic [6:0] enc [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  register_reader #(.WIDTH(32), .ADDR_W(5), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .next(next), .half_sel(half_sel), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .seg(seg), .an(an), .dp(dp));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [4:0] a);
    return a == 5'd1 ? 32'h1234ABCD : 32'hA0000000 | {27'd0, a};
  endfunction
  always @(posedge clk) if (rd_en) rd_data <= ff_mode ? 32'hFFFFFFFF : mem(rd_addr);
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic go_phase(input int ph);
    while (cyc % 16 != ph) tick();
  endtask
  task automatic disp(input int n, input logic [31:0] sh, input logic hs);
    logic [3:0] seen = '0;
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      int idx = -1;
      tick();
      for (int i = 0; i < 4; i++) if (an === ~(4'b0001 << i)) idx = i;
      chk("an_onehot", {31'd0, idx >= 0}, 32'd1);
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        w = sh >> (16 * hs + 4 * idx);
        chk("seg_digit", {25'd0, seg}, {25'd0, enc[w[3:0]]});
        chk("dp", {31'd0, dp}, {31'd0, !(hs && idx == 3)});
      end
    end
    chk("digits_seen", {28'd0, seen}, 32'hF);
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_an", {28'd0, an}, 32'b1110);
    chk("rst_seg", {25'd0, seg}, 32'b1000000);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_addr", {27'd0, rd_addr}, 32'd0);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("no_rd_before_wrap", {31'd0, rd_en}, 32'd0);
    end
    tick();
    chk("wrap_rd_en", {31'd0, rd_en}, 32'd1);
    chk("wrap_addr", {27'd0, rd_addr}, 32'd0);
    tick();
    chk("wrap_rd_en_1cyc", {31'd0, rd_en}, 32'd0);
    tick();
    chk("shadow_addr0", dut.r_shadow, 32'hA0000000);
    go_phase(4);
    next = 1'b1;
    tick();
    next = 1'b0;
    chk("next_rd_en", {31'd0, rd_en}, 32'd1);
    chk("next_addr", {27'd0, rd_addr}, 32'd1);
    tick();
    chk("next_rd_en_1cyc", {31'd0, rd_en}, 32'd0);
    chk("shadow_not_yet", dut.r_shadow, 32'hA0000000);
    tick();
    chk("shadow_addr1", dut.r_shadow, 32'h1234ABCD);
    tick();
    disp(16, 32'h1234ABCD, 1'b0);
    half_sel = 1'b1;
    tick();
    disp(16, 32'h1234ABCD, 1'b1);
    half_sel = 1'b0;
    go_phase(0);
    chk("reread_rd_en", {31'd0, rd_en}, 32'd1);
    chk("reread_addr", {27'd0, rd_addr}, 32'd1);
    next = 1'b1;
    tick();
    chk("pend_hold_addr_a", {27'd0, rd_addr}, 32'd1);
    next = 1'b0;
    tick();
    chk("pend_hold_addr_b", {27'd0, rd_addr}, 32'd1);
    next = 1'b1;
    tick();
    chk("pend_service_rd_en", {31'd0, rd_en}, 32'd1);
    chk("pend_service_addr", {27'd0, rd_addr}, 32'd2);
    next = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pend_single_incr", {27'd0, rd_addr}, 32'd2);
    end
    chk("shadow_addr2", dut.r_shadow, 32'hA0000002);
    for (int i = 0; i < 29; i++) begin
      next = 1'b1;
      tick();
      tick();
      next = 1'b0;
      tick();
      tick();
    end
    repeat (8) tick();
    chk("addr_31", {27'd0, rd_addr}, 32'd31);
    go_phase(4);
    next = 1'b1;
    tick();
    next = 1'b0;
    chk("addr_wrap0", {27'd0, rd_addr}, 32'd0);
    chk("addr_wrap0_rd_en", {31'd0, rd_en}, 32'd1);
    repeat (2) tick();
    chk("shadow_wrap0", dut.r_shadow, 32'hA0000000);
    ff_mode = 1'b1;
    go_phase(4);
    next = 1'b1;
    tick();
    next = 1'b0;
    chk("abort_issue", {31'd0, rd_en}, 32'd1);
    tick();
    chk("abort_in_capture", {31'd0, rd_en}, 32'd0);
    reset = 1'b1;
    tick();
    chk("abort_shadow", dut.r_shadow, 32'd0);
    chk("abort_addr", {27'd0, rd_addr}, 32'd0);
    chk("abort_rd_en", {31'd0, rd_en}, 32'd0);
    chk("abort_seg", {25'd0, seg}, 32'b1000000);
    chk("abort_an", {28'd0, an}, 32'b1110);
    reset = 1'b0;
    repeat (3) tick();
    chk("abort_shadow_after", dut.r_shadow, 32'd0);
    chk("abort_seg_after", {25'd0, seg}, 32'b1000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
